// File: rtl/tree_result_dispatcher_pkg.sv
// tree_result_dispatcher_pkg: shared state encoding and counter width for the dispatcher
package tree_result_dispatcher_pkg;
  localparam int COUNT_W = 16;
  typedef enum logic {IDLE, DISPATCH} state_e;
endpackage

// File: rtl/tree_result_dispatcher_or.sv
// tree_or_reducer: balanced OR tree of depth ceil(log2(N)) built by recursive halving
module tree_or_reducer #(
  parameter int N = 6
) (
  input  logic [N-1:0] in_bits,
  output logic         or_out
);
  localparam int L = (N + 1) / 2;
  generate
    if (N == 1) begin : g_leaf
      assign or_out = in_bits[0];
    end else begin : g_node
      logic lo_or;
      logic hi_or;
      tree_or_reducer #(.N(L)) u_lo (.in_bits(in_bits[L-1:0]), .or_out(lo_or));
      tree_or_reducer #(.N(N-L)) u_hi (.in_bits(in_bits[N-1:L]), .or_out(hi_or));
      assign or_out = lo_or | hi_or;
    end
  endgenerate
endmodule

// File: rtl/tree_result_dispatcher.sv
// tree_result_dispatcher: latches one value and broadcasts it to a mask of channels until all accept
module tree_result_dispatcher
  import tree_result_dispatcher_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_COUNT = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DATA_WIDTH-1:0]    in_value,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [CHANNEL_COUNT-1:0] channel_mask,
  output logic [DATA_WIDTH-1:0]    out_value,
  output logic [CHANNEL_COUNT-1:0] out_valids,
  input  logic [CHANNEL_COUNT-1:0] out_readys,
  output logic                     busy,
  output logic [COUNT_W-1:0]       dispatch_count
);
  state_e                   state_q, state_d;
  logic [CHANNEL_COUNT-1:0] pending_q, pending_d;
  logic [DATA_WIDTH-1:0]    value_q, value_d;
  logic [COUNT_W-1:0]       count_q, count_d;
  logic                     accept;
  logic                     left;
  assign busy           = state_q == DISPATCH;
  assign in_ready       = state_q == IDLE && !reset;
  assign out_valids     = busy ? pending_q : '0;
  assign out_value      = value_q;
  assign dispatch_count = count_q;
  assign accept         = in_valid && in_ready;
  // left is high while any pending channel has not yet taken the value
  tree_or_reducer #(.N(CHANNEL_COUNT)) u_done (
    .in_bits(pending_q & ~out_readys),
    .or_out (left)
  );
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    value_d   = value_q;
    count_d   = count_q;
    if (state_q == IDLE) begin
      if (accept) begin
        value_d   = in_value;
        pending_d = channel_mask;
        state_d   = channel_mask == '0 ? IDLE : DISPATCH;
        count_d   = channel_mask == '0 ? count_q + COUNT_W'(1) : count_q;
      end
    end else begin
      pending_d = pending_q & ~out_readys;
      state_d   = left ? DISPATCH : IDLE;
      count_d   = left ? count_q : count_q + COUNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      value_q   <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      value_q   <= value_d;
      count_q   <= count_d;
    end
  end
endmodule
